// File: rtl/julia_pixel_engine.sv
// Julia-set escape-time generator: sweeps the frame, iterates z <= z^2 + c per pixel and
// streams one RGB565 word plus its SRAM address per pixel over a valid/ready handshake.
module julia_pixel_engine #(
   parameter int W        = 18,
   parameter int FRAC     = 14,
   parameter int MAX_ITER = 255,
   parameter int H_RES    = 800,
   parameter int V_RES    = 480
) (
   input  logic         i_CLK,
   input  logic         i_RST_N,
   input  logic         i_Begin,
   input  logic [W-1:0] i_CRe,
   input  logic [W-1:0] i_CIm,
   input  logic [W-1:0] i_X0,
   input  logic [W-1:0] i_Y0,
   input  logic [W-1:0] i_Step,
   input  logic         i_Ready,
   output logic         o_Valid,
   output logic [18:0]  o_Addr,
   output logic [15:0]  o_Data,
   output logic [7:0]   o_Iter,
   output logic         o_Busy,
   output logic         o_Done
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_ITER = 3'd2;
   localparam logic [2:0] S_EMIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int PW = 2*W + 1;
   localparam logic signed [PW-1:0] ESC_LIM = PW'(4) <<< (2*FRAC);
   localparam logic [7:0] ITER_CAP = 8'(MAX_ITER);

   logic [2:0]          state_q, state_d;
   logic signed [W-1:0] cre_q, cre_d, cim_q, cim_d, x0_q, x0_d, step_q, step_d;
   logic signed [W-1:0] zr0_q, zr0_d, zi0_q, zi0_d, zr_q, zr_d, zi_q, zi_d;
   logic [9:0]          x_q, x_d;
   logic [8:0]          y_q, y_d;
   logic [7:0]          iter_q, iter_d, cnt_q, cnt_d;

   logic signed [2*W-1:0] zr_x, zi_x, p_rr, p_ii, p_ri;
   logic signed [PW-1:0]  mag, diff;
   logic signed [W-1:0]   zr_upd, zi_upd;
   logic                  last_px;

   // Full-precision products; the escape test sees the untruncated magnitude.
   assign zr_x   = (2*W)'(zr_q);
   assign zi_x   = (2*W)'(zi_q);
   assign p_rr   = zr_x * zr_x;
   assign p_ii   = zi_x * zi_x;
   assign p_ri   = zr_x * zi_x;
   assign mag    = PW'(p_rr) + PW'(p_ii);
   assign diff   = PW'(p_rr) - PW'(p_ii);
   assign zr_upd = W'(diff >>> FRAC) + cre_q;
   assign zi_upd = W'(p_ri >>> (FRAC-1)) + cim_q;   // 2*zr*zi folded into the shift
   assign last_px = (x_q == 10'(H_RES-1)) && (y_q == 9'(V_RES-1));

   always_comb begin
      state_d = state_q;
      cre_d = cre_q;  cim_d = cim_q;  x0_d = x0_q;  step_d = step_q;
      zr0_d = zr0_q;  zi0_d = zi0_q;  zr_d = zr_q;  zi_d = zi_q;
      x_d = x_q;  y_d = y_q;  iter_d = iter_q;  cnt_d = cnt_q;
      case (state_q)
         S_IDLE: if (i_Begin) begin
            cre_d = i_CRe;  cim_d = i_CIm;  x0_d = i_X0;  step_d = i_Step;
            x_d = '0;  y_d = '0;  zr0_d = i_X0;  zi0_d = i_Y0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            zr_d = zr0_q;  zi_d = zi0_q;  iter_d = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (mag > ESC_LIM) begin
               cnt_d = iter_q;  state_d = S_EMIT;
            end else if (iter_q == ITER_CAP) begin
               cnt_d = ITER_CAP;  state_d = S_EMIT;
            end else begin
               zr_d = zr_upd;  zi_d = zi_upd;  iter_d = iter_q + 8'd1;
            end
         end
         S_EMIT: if (i_Ready) begin
            if (last_px) state_d = S_DONE;
            else begin
               state_d = S_LOAD;
               if (x_q == 10'(H_RES-1)) begin
                  x_d = '0;  zr0_d = x0_q;  y_d = y_q + 9'd1;  zi0_d = zi0_q - step_q;
               end else begin
                  x_d = x_q + 10'd1;  zr0_d = zr0_q + step_q;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= S_IDLE;
         cre_q <= '0;  cim_q <= '0;  x0_q <= '0;  step_q <= '0;
         zr0_q <= '0;  zi0_q <= '0;  zr_q <= '0;  zi_q <= '0;
         x_q <= '0;  y_q <= '0;  iter_q <= '0;  cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cre_q <= cre_d;  cim_q <= cim_d;  x0_q <= x0_d;  step_q <= step_d;
         zr0_q <= zr0_d;  zi0_q <= zi0_d;  zr_q <= zr_d;  zi_q <= zi_d;
         x_q <= x_d;  y_q <= y_d;  iter_q <= iter_d;  cnt_q <= cnt_d;
      end
   end

   assign o_Valid = (state_q == S_EMIT);
   assign o_Addr  = o_Valid ? {y_q, x_q} : 19'd0;
   assign o_Iter  = o_Valid ? cnt_q : 8'd0;
   assign o_Data  = (o_Valid && cnt_q != ITER_CAP) ? {cnt_q[4:0], cnt_q[5:0], cnt_q[4:0]} : 16'h0000;
   assign o_Busy  = (state_q != S_IDLE);
   assign o_Done  = (state_q == S_DONE);
endmodule

// File: tb/tb_julia_pixel_engine.sv
// Scoreboard bench for julia_pixel_engine on a small 4x3 frame: a reference model fills the
// expected-word queue per frame and a negedge monitor compares every accepted word.
module tb_julia_pixel_engine;
   localparam int W = 18, FRAC = 14, MI = 255, H = 4, V = 3;

   logic         clk = 1'b0, rst_n = 1'b0, begin_i = 1'b0, ready = 1'b0;
   logic [W-1:0] cre = '0, cim = '0, x0 = '0, y0 = '0, step = '0;
   logic         valid, busy, done;
   logic [18:0]  addr;
   logic [15:0]  data;
   logic [7:0]   iter;

   julia_pixel_engine #(.W(W), .FRAC(FRAC), .MAX_ITER(MI), .H_RES(H), .V_RES(V)) dut (
      .i_CLK(clk), .i_RST_N(rst_n), .i_Begin(begin_i), .i_CRe(cre), .i_CIm(cim),
      .i_X0(x0), .i_Y0(y0), .i_Step(step), .i_Ready(ready), .o_Valid(valid),
      .o_Addr(addr), .o_Data(data), .o_Iter(iter), .o_Busy(busy), .o_Done(done));

   always #5 clk = ~clk;

   typedef struct { logic [18:0] addr; logic [7:0] it; logic [15:0] data; } exp_t;
   exp_t q[$];
   int   checks = 0, errors = 0;
   bit   rand_rdy = 1'b0, rdy_val = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sx(input longint v);
      longint r;
      r = v & ((longint'(1) << W) - 1);
      if (r >= (longint'(1) << (W-1))) r -= (longint'(1) << W);
      return r;
   endfunction

   // Escape-time of one pixel in plain integer arithmetic.
   function automatic int ref_iter(input longint cr, input longint ci, input longint zr_in, input longint zi_in);
      longint zr, zi, nr, ni;
      zr = zr_in;  zi = zi_in;
      for (int it = 0; it <= MI; it++) begin
         if (zr*zr + zi*zi > (longint'(4) << (2*FRAC))) return it;
         if (it == MI) return MI;
         nr = sx(((zr*zr - zi*zi) >>> FRAC) + cr);
         ni = sx(((2*zr*zi) >>> FRAC) + ci);
         zr = nr;  zi = ni;
      end
      return MI;
   endfunction

   task automatic push_frame(input logic signed [W-1:0] cr, ci, px, py, ps);
      exp_t e;
      logic [7:0] c8;
      int n;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) begin
            n  = ref_iter(longint'(cr), longint'(ci), sx(longint'(px) + x*longint'(ps)),
                          sx(longint'(py) - y*longint'(ps)));
            c8 = 8'(n);
            e.addr = {9'(y), 10'(x)};
            e.it   = c8;
            e.data = (n == MI) ? 16'h0000 : {c8[4:0], c8[5:0], c8[4:0]};
            q.push_back(e);
         end
   endtask

   // Issues Begin, then scrambles the inputs; returns edges from Begin to first o_Valid.
   task automatic start_frame(input logic signed [W-1:0] cr, ci, px, py, ps, output int lat);
      push_frame(cr, ci, px, py, ps);
      @(posedge clk); #1;
      cre = cr;  cim = ci;  x0 = px;  y0 = py;  step = ps;  begin_i = 1'b1;
      @(posedge clk); #1;
      begin_i = 1'b0;
      cre = W'($urandom);  cim = W'($urandom);  x0 = W'($urandom);  y0 = W'($urandom);  step = W'($urandom);
      lat = 1;
      while (!valid && lat < 400) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!done && n < budget) begin @(posedge clk); #1; n++; end
      check({name, "_done_seen"}, done, 1'b1);
      check({name, "_queue_empty"}, q.size(), 0);
      @(posedge clk); #1;
      check({name, "_done_one_cycle"}, done, 1'b0);
      check({name, "_idle_after"}, busy, 1'b0);
   endtask

   initial forever begin
      @(posedge clk); #2;
      ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   // Monitor: compares accepted words and checks hold stability under back-pressure.
   bit          hold = 1'b0;
   logic [18:0] h_addr;
   logic [15:0] h_data;
   logic [7:0]  h_iter;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) hold = 1'b0;
      else begin
         if (hold) begin
            check("hold_valid", valid, 1'b1);
            check("hold_addr", addr, h_addr);
            check("hold_data", data, h_data);
            check("hold_iter", iter, h_iter);
         end
         if (valid && ready) begin
            if (q.size() == 0) check("unexpected_word_addr", addr, 19'h7FFFF);
            else begin
               e = q.pop_front();
               check("word_addr", addr, e.addr);
               check("word_iter", iter, e.it);
               check("word_data", data, e.data);
            end
         end
         hold = valid && !ready;
         h_addr = addr;  h_data = data;  h_iter = iter;
      end
   end

   initial begin
      int lat;
      logic [18:0] a0;
      logic [15:0] d0;
      logic [7:0]  i0;
      #2;
      check("rst_valid", valid, 0);  check("rst_addr", addr, 0);  check("rst_data", data, 0);
      check("rst_iter", iter, 0);    check("rst_busy", busy, 0);  check("rst_done", done, 0);
      #10 rst_n = 1'b1;

      // all pixels escape immediately
      rand_rdy = 0;  rdy_val = 1;
      start_frame(0, 0, 18'h0C000, 0, 0, lat);
      check("t1_latency", lat, 3);
      wait_done("t1", 200);

      // interior pixels hit the cap
      start_frame(0, 0, 0, 0, 0, lat);
      check("t2_latency", lat, 258);
      check("t2_iter", iter, 8'd255);
      check("t2_data", data, 16'h0000);
      wait_done("t2", 12*270);

      // one iteration before escape
      start_frame(0, 0, 18'h06000, 0, 0, lat);
      check("t3_latency", lat, 4);
      check("t3_iter", iter, 8'd1);
      check("t3_data", data, 16'h0821);
      wait_done("t3", 200);

      // back-pressure for 10 cycles
      rdy_val = 0;
      start_frame(0, 0, 18'h0C000, 0, 18'h00800, lat);
      #1;
      a0 = addr;  d0 = data;  i0 = iter;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("t4_stall_valid", valid, 1'b1);
         check("t4_stall_addr", addr, a0);
         check("t4_stall_data", data, d0);
         check("t4_stall_iter", iter, i0);
      end
      rdy_val = 1;
      wait_done("t4", 400);

      // Begin while busy is ignored
      rand_rdy = 1;
      start_frame(18'h3E000, 18'h00800, 18'h3C000, 18'h02000, 18'h01000, lat);
      repeat (15) @(posedge clk);
      #1 begin_i = 1'b1;  cre = 0;  cim = 0;  x0 = 0;  y0 = 0;  step = 0;
      @(posedge clk); #1 begin_i = 1'b0;
      wait_done("t5", 12*270);

      // reset mid-ITER
      start_frame(0, 0, 0, 0, 0, lat);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t6_valid", valid, 0);  check("t6_addr", addr, 0);  check("t6_data", data, 0);
      check("t6_iter", iter, 0);    check("t6_busy", busy, 0);  check("t6_done", done, 0);
      q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rand_rdy = 0;  rdy_val = 1;
      start_frame(0, 0, 18'h0C000, 0, 0, lat);
      check("t6_restart_latency", lat, 3);
      wait_done("t6", 200);

      // randomized frames
      rand_rdy = 1;
      for (int f = 0; f < 5; f++) begin
         start_frame(W'(int'($urandom_range(0, 32768)) - 16384),
                     W'(int'($urandom_range(0, 32768)) - 16384),
                     W'(-int'($urandom_range(0, 24576))),
                     W'(int'($urandom_range(0, 19660))),
                     W'(int'($urandom_range(0, 4915))), lat);
         wait_done("rand", 12*270);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
